// File: rtl/spike_rate_monitor_if.sv
// Result port of the spike rate monitor: a windowed spike count offered on a valid/ready handshake.
// The master side produces the result and the slave side consumes it.
interface spike_rate_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic [CNT_W-1:0] rate_out;
    logic             rate_valid;
    logic             rate_ready;

    modport master (
        output rate_out,
        output rate_valid,
        input  rate_ready
    );

    modport slave (
        input  rate_out,
        input  rate_valid,
        output rate_ready
    );
endinterface

// File: rtl/spike_rate_monitor.sv
// Spike rate monitor: counts neuron spikes over back-to-back programmable windows and measures
// the most recent inter-spike interval.
// Optional burst detector enabled by defining SPIKE_RATE_MONITOR_BURST_EN.
module spike_rate_monitor #(
    parameter int unsigned WIN_W     = 8,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned ISI_W     = 8,
    parameter int unsigned BURST_ISI = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spike,
    input  logic                 enable,
    input  logic [WIN_W-1:0]     win_len,
    spike_rate_monitor_if.master rate_if,
    output logic                 overrun,
    output logic [ISI_W-1:0]     isi_out,
    output logic                 isi_valid,
    output logic                 burst
);

    typedef enum logic [0:0] {StIdle, StCount} state_e;

    localparam logic [WIN_W-1:0] WinOne = WIN_W'(1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [ISI_W-1:0] IsiOne = ISI_W'(1);

    // A threshold the ISI counter can never reach would make the detector meaningless.
    if (BURST_ISI >= (64'd1 << ISI_W)) begin : g_bad_burst_isi
        $error("BURST_ISI does not fit in ISI_W bits");
    end

    state_e           state_q, state_d;
    logic [WIN_W-1:0] len_q, len_d;
    logic [WIN_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] spk_q, spk_d;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic             rate_valid_q, rate_valid_d;
    logic             overrun_q, overrun_d;
    logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
    logic [ISI_W-1:0] isi_out_q, isi_out_d;
    logic             isi_valid_q, isi_valid_d;
    logic             isi_seen_q, isi_seen_d;

    logic [WIN_W-1:0] len_in;
    logic [CNT_W-1:0] spk_inc;
    logic             win_done;
    logic [CNT_W-1:0] win_result;

    // A zero window length is treated as a one-cycle window.
    assign len_in  = (win_len == '0) ? WinOne : win_len;
    // Spike count including this cycle's spike, saturating at all-ones.
    assign spk_inc = (spike && (spk_q != '1)) ? spk_q + CntOne : spk_q;

    // Window FSM state and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            cyc_q   <= '0;
            spk_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cyc_q   <= cyc_d;
            spk_q   <= spk_d;
        end
    end

    // Window sequencing: start, count, end-of-window result, abort on enable drop.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cyc_d      = cyc_q;
        spk_d      = spk_q;
        win_done   = 1'b0;
        win_result = spk_q;
        unique case (state_q)
            StIdle: begin
                cyc_d = '0;
                spk_d = '0;
                if (enable) begin
                    len_d   = len_in;
                    state_d = StCount;
                end
            end
            StCount: begin
                if (cyc_q == len_q - WinOne) begin
                    // Last cycle of the window; its spike belongs to this result.
                    win_done   = 1'b1;
                    win_result = spk_inc;
                    cyc_d      = '0;
                    spk_d      = '0;
                    if (enable) begin
                        len_d = len_in;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (!enable) begin
                    // Abort: the partial count is discarded.
                    state_d = StIdle;
                    cyc_d   = '0;
                    spk_d   = '0;
                end else begin
                    cyc_d = cyc_q + WinOne;
                    spk_d = spk_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Result port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    // Result handshake: a new result wins over acceptance; overwriting an unaccepted one is sticky.
    always_comb begin
        rate_d       = rate_q;
        rate_valid_d = rate_valid_q;
        overrun_d    = overrun_q;
        if (win_done) begin
            rate_d       = win_result;
            rate_valid_d = 1'b1;
            if (rate_valid_q && !rate_if.rate_ready) begin
                overrun_d = 1'b1;
            end
        end else if (rate_valid_q && rate_if.rate_ready) begin
            rate_valid_d = 1'b0;
        end
    end

    // Inter-spike interval registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            isi_cnt_q   <= '0;
            isi_out_q   <= '0;
            isi_valid_q <= 1'b0;
            isi_seen_q  <= 1'b0;
        end else begin
            isi_cnt_q   <= isi_cnt_d;
            isi_out_q   <= isi_out_d;
            isi_valid_q <= isi_valid_d;
            isi_seen_q  <= isi_seen_d;
        end
    end

    // ISI counter runs regardless of window state; a spike reports it once a prior spike exists.
    always_comb begin
        isi_cnt_d   = (isi_cnt_q != '1) ? isi_cnt_q + IsiOne : isi_cnt_q;
        isi_out_d   = isi_out_q;
        isi_valid_d = 1'b0;
        isi_seen_d  = isi_seen_q;
        if (spike) begin
            isi_cnt_d  = IsiOne;
            isi_seen_d = 1'b1;
            if (isi_seen_q) begin
                isi_out_d   = isi_cnt_q;
                isi_valid_d = 1'b1;
            end
        end
    end

`ifdef SPIKE_RATE_MONITOR_BURST_EN
    localparam logic [ISI_W-1:0] BurstIsi = ISI_W'(BURST_ISI);

    logic burst_q, burst_d;

    // Burst flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q <= 1'b0;
        end else begin
            burst_q <= burst_d;
        end
    end

    // Burst follows each ISI update and times out once the gap grows past the threshold.
    always_comb begin
        burst_d = burst_q;
        if (spike && isi_seen_q) begin
            burst_d = (isi_cnt_q <= BurstIsi);
        end else if (!spike && (isi_cnt_q > BurstIsi)) begin
            burst_d = 1'b0;
        end
    end

    assign burst = burst_q;
`else
    assign burst = 1'b0;
`endif

    assign rate_if.rate_out   = rate_q;
    assign rate_if.rate_valid = rate_valid_q;
    assign overrun            = overrun_q;
    assign isi_out            = isi_out_q;
    assign isi_valid          = isi_valid_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Self-checking bench for spike_rate_monitor: directed scenarios followed by random stimulus,
// all outputs compared every cycle against a time-based reference model.
module tb_spike_rate_monitor;

    localparam int WIN_W     = 8;
    localparam int CNT_W     = 8;
    localparam int ISI_W     = 8;
    localparam int BURST_ISI = 4;
    localparam int HIST_LEN  = 8192;

    logic             clk = 1'b0;
    logic             rst;
    logic             spike;
    logic             enable;
    logic [WIN_W-1:0] win_len;
    logic             overrun;
    logic [ISI_W-1:0] isi_out;
    logic             isi_valid;
    logic             burst;

    spike_rate_monitor_if #(.CNT_W(CNT_W)) rif ();

    spike_rate_monitor #(
        .WIN_W    (WIN_W),
        .CNT_W    (CNT_W),
        .ISI_W    (ISI_W),
        .BURST_ISI(BURST_ISI)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .spike    (spike),
        .enable   (enable),
        .win_len  (win_len),
        .rate_if  (rif),
        .overrun  (overrun),
        .isi_out  (isi_out),
        .isi_valid(isi_valid),
        .burst    (burst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: windows are time ranges over a spike history, ISI is a time difference.
    int t = 0;
    bit hist [HIST_LEN];
    bit running = 1'b0;
    int win_start = 0;
    int m_len = 1;
    int m_rate = 0;
    bit m_valid = 1'b0;
    bit m_ovr = 1'b0;
    int last_spk = -1;
    int m_isi = 0;
    bit m_isi_v = 1'b0;
    bit m_burst = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, t);
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model(input bit sp, input bit en, input int wl, input bit rr, input bit rs);
        bit done;
        int res;
        done = 1'b0;
        res  = 0;
        hist[t] = sp;
        if (rs) begin
            running  = 1'b0;
            m_rate   = 0;
            m_valid  = 1'b0;
            m_ovr    = 1'b0;
            last_spk = -1;
            m_isi    = 0;
            m_isi_v  = 1'b0;
            m_burst  = 1'b0;
        end else begin
            if (running) begin
                if (t == win_start + m_len - 1) begin
                    done = 1'b1;
                    for (int i = win_start; i <= t; i++) res += int'(hist[i]);
                    if (en) begin
                        win_start = t + 1;
                        m_len     = (wl == 0) ? 1 : wl;
                    end else begin
                        running = 1'b0;
                    end
                end else if (!en) begin
                    running = 1'b0;
                end
            end else if (en) begin
                running   = 1'b1;
                win_start = t + 1;
                m_len     = (wl == 0) ? 1 : wl;
            end
            if (done) begin
                if (m_valid && !rr) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_rate  = sat(res, CNT_W);
            end else if (m_valid && rr) begin
                m_valid = 1'b0;
            end
            m_isi_v = 1'b0;
            if (sp) begin
                if (last_spk >= 0) begin
                    m_isi   = sat(t - last_spk, ISI_W);
                    m_isi_v = 1'b1;
`ifdef SPIKE_RATE_MONITOR_BURST_EN
                    m_burst = (m_isi <= BURST_ISI);
`endif
                end
                last_spk = t;
            end else begin
`ifdef SPIKE_RATE_MONITOR_BURST_EN
                if (last_spk >= 0 && (t - last_spk) > BURST_ISI) m_burst = 1'b0;
`endif
            end
        end
        t++;
    endtask

    task automatic step(input bit sp, input bit en, input int wl, input bit rr, input bit rs);
        @(negedge clk);
        spike          = sp;
        enable         = en;
        win_len        = WIN_W'(wl);
        rif.rate_ready = rr;
        rst            = rs;
        @(posedge clk);
        model(sp, en, wl, rr, rs);
        #1;
        check_eq("rate_out",   int'(rif.rate_out),   m_rate);
        check_eq("rate_valid", int'(rif.rate_valid), int'(m_valid));
        check_eq("overrun",    int'(overrun),        int'(m_ovr));
        check_eq("isi_valid",  int'(isi_valid),      int'(m_isi_v));
        check_eq("isi_out",    int'(isi_out),        m_isi);
        check_eq("burst",      int'(burst),          int'(m_burst));
    endtask

    initial begin
        int exp_burst;
`ifdef SPIKE_RATE_MONITOR_BURST_EN
        exp_burst = 1;
`else
        exp_burst = 0;
`endif
        rst            = 1'b1;
        spike          = 1'b0;
        enable         = 1'b0;
        win_len        = '0;
        rif.rate_ready = 1'b0;

        // Reset with spike toggling.
        step(1'b1, 1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        check_eq("reset_rate_valid", int'(rif.rate_valid), 0);
        check_eq("reset_isi_valid", int'(isi_valid), 0);

        // Window of 10 with spikes on counted cycles 0, 3, 9.
        step(1'b0, 1'b1, 10, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(i == 0 || i == 3 || i == 9, 1'b1, 10, 1'b0, 1'b0);
        check_eq("win10_rate", int'(rif.rate_out), 3);
        check_eq("win10_valid", int'(rif.rate_valid), 1);

        // Two more windows unaccepted: 2 spikes, then 5 spikes.
        for (int i = 0; i < 10; i++) step(i == 1 || i == 5, 1'b1, 10, 1'b0, 1'b0);
        check_eq("win2_rate", int'(rif.rate_out), 2);
        for (int i = 0; i < 10; i++) step(i % 2 == 0, 1'b1, 10, 1'b0, 1'b0);
        check_eq("win3_rate", int'(rif.rate_out), 5);
        check_eq("win3_overrun", int'(overrun), 1);

        // Accept, then abort at cycle 4 after 2 spikes.
        step(1'b0, 1'b1, 10, 1'b1, 1'b0);
        check_eq("accept_valid", int'(rif.rate_valid), 0);
        check_eq("accept_overrun", int'(overrun), 1);
        step(1'b1, 1'b1, 10, 1'b0, 1'b0);
        step(1'b1, 1'b1, 10, 1'b0, 1'b0);
        step(1'b0, 1'b1, 10, 1'b0, 1'b0);
        step(1'b0, 1'b0, 10, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 10, 1'b0, 1'b0);
        check_eq("abort_rate", int'(rif.rate_out), 5);
        check_eq("abort_valid", int'(rif.rate_valid), 0);

        // ISI: spikes at relative cycles 5, 12, 13.
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(i == 5 || i == 12 || i == 13, 1'b0, 0, 1'b0, 1'b0);
            if (i == 5) check_eq("isi_first_valid", int'(isi_valid), 0);
            if (i == 12) begin
                check_eq("isi7_valid", int'(isi_valid), 1);
                check_eq("isi7_value", int'(isi_out), 7);
            end
            if (i == 13) begin
                check_eq("isi1_value", int'(isi_out), 1);
                check_eq("isi1_burst", int'(burst), exp_burst);
            end
        end

        // win_len of 0 acts as a one-cycle window.
        step(1'b0, 1'b1, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check_eq("win0_rate", int'(rif.rate_out), 1);
        check_eq("win0_valid", int'(rif.rate_valid), 1);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0);

        // Saturation: spike held high for 300 cycles with a 255-cycle window.
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 255, 1'b0, 1'b0);
        check_eq("sat_rate", int'(rif.rate_out), 255);
        check_eq("sat_isi", int'(isi_out), 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);

        // Random traffic with mixed densities, window lengths, back-pressure and rare resets.
        for (int i = 0; i < 3000; i++) begin
            bit sp;
            if ((i / 200) % 2 == 0) sp = ($urandom_range(0, 3) == 0);
            else sp = ($urandom_range(0, 1) == 0);
            step(sp, $urandom_range(0, 19) != 0, int'($urandom_range(0, 12)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 499) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
